capture_timer_ctrl: RTL
=======================

// Module: capture_timer_ctrl
// PURPOSE
//   Sequences the timestamp-capture datapath fed by the edge detector's
//   start/capture/rst_capture rising-edge pulses.
//   Runs a free-running timestamp counter under an IDLE/RUN/HOLD state machine
//   and pushes the counter value into a small capture FIFO on each capture edge.
//   Host drains captures through a valid/ready read port.
// PARAMETERS
//   CNT_W   32  timestamp counter / capture data width
//   DEPTH   4   capture FIFO entries; power of 2, >= 2
//   LVL_W   3   level width = clog2(DEPTH)+1 (localparam, derived, not overridable)
// PORTS
//   clk_i               in   1      single clock, all logic on rising edge
//   rst_an_i            in   1      reset, asynchronous, active-low
//   start_rise_i        in   1      1-cycle start rising-edge pulse
//   capture_rise_i      in   1      1-cycle capture rising-edge pulse
//   rst_capture_rise_i  in   1      1-cycle rst_capture rising-edge pulse
//   rd_ready_i          in   1      host accepts rd_data_o this cycle
//   rd_valid_o          out  1      FIFO non-empty; rd_data_o holds oldest entry
//   rd_data_o           out  CNT_W  oldest captured timestamp (first-word-fall-through)
//   count_o             out  CNT_W  current counter value
//   running_o           out  1      state == RUN
//   level_o             out  LVL_W  FIFO occupancy, 0..DEPTH
//   overflow_o          out  1      sticky: capture dropped because FIFO full
//   wrap_o              out  1      sticky: counter wrapped all-ones -> 0
// BEHAVIOUR
//   Reset (rst_an_i low, async): state=IDLE; count_o=0; FIFO empty; rd_valid_o=0;
//     rd_data_o=0; level_o=0; overflow_o=0; wrap_o=0; running_o=0.
//   FSM, evaluated each clock; priority: rst_capture > start:
//     any state + rst_capture_rise -> IDLE; count=0; FIFO flushed; overflow/wrap
//       cleared; a read, capture or start in that cycle is ignored.
//     IDLE + start_rise -> RUN, count loaded 0 (first increment next cycle).
//     RUN  + start_rise -> HOLD (count frozen at its current value).
//     HOLD + start_rise -> RUN (count resumes from the frozen value).
//   Counter: +1 per cycle in RUN only; all-ones -> 0 sets wrap_o; no saturation.
//   Capture: capture_rise in RUN or HOLD pushes the count_o value of that same
//     cycle (pre-increment). Ignored in IDLE, no flag.
//     start_rise in the same cycle: capture is still taken with that cycle's count_o.
//   FIFO push/pop:
//     push when full and no pop: entry dropped, overflow_o=1 next cycle.
//     full + push + pop (rd_valid_o & rd_ready_i) same cycle: both occur, level
//       unchanged, no overflow.
//     empty + push: rd_valid_o=1 and rd_data_o valid the next cycle (1-cycle latency).
//     rd_ready_i with rd_valid_o=0: no effect.
//   Read: rd_data_o/rd_valid_o are stable while rd_valid_o=1 and rd_ready_i=0.
//   Pointers: LVL_W-1 bits, wrap modulo DEPTH; level_o = pushes - pops.
//   All outputs registered; no combinational input->output path except none.
// STRUCTURE
//   Shared package capture_pkg: FSM state encoding (ST_IDLE=2'd0, ST_RUN=2'd1,
//     ST_HOLD=2'd2) and defaults CNT_W/DEPTH, reused by the register block and
//     the top level.
//   Sub-module capture_fifo (DEPTH x CNT_W, FWFT, push/pop/flush, level, full/empty).
//   Top holds the FSM, the counter, sticky flags and the FIFO instance.
// TESTING
//   1 reset, start_rise, 10 idle cycles, capture_rise -> rd_valid_o=1 next cycle,
//     rd_data_o=10; ready -> level_o=0.
//   2 RUN; start_rise at count 5 -> HOLD, count_o stays 5 for 20 cycles;
//     start_rise -> resumes 6, 7, ...
//   3 5 captures, no reads (DEPTH=4) -> level_o=4, overflow_o=1; the 5th value
//     is absent from readout; reads return the first 4 in order.
//   4 FIFO full; capture with rd_ready_i=1 same cycle -> level_o stays 4,
//     overflow_o=0, new value last.
//   5 CNT_W=8: run 256 cycles -> count_o wraps to 0, wrap_o=1; rst_capture_rise
//     -> IDLE, count_o=0, level_o=0, flags 0.
//   6 rst_capture_rise and capture_rise and start_rise together in RUN -> IDLE,
//     FIFO empty, no push; async rst_an_i mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the timestamp-capture block: FSM encoding and default sizes.
package capture_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage : capture_pkg

// File: rtl/capture_fifo.sv
// First-word-fall-through capture FIFO with registered head data, level and flags.
module capture_fifo #(
  parameter  int unsigned W     = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1,
  localparam int unsigned PTR_W = LVL_W - 1
) (
  input  logic             clk_i,
  input  logic             rst_an_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [W-1:0]     data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [W-1:0]     data_q, data_d;
  logic             valid_q, full_q;
  logic             do_push, do_pop;
  logic [W-1:0]     head_d;

  // A push into a full FIFO only lands when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop   = pop_i & valid_q & ~flush_i;
    do_push  = push_i & (~full_q | do_pop) & ~flush_i;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    head_d   = (do_push && (wr_ptr_q == rd_ptr_d)) ? data_i : mem_q[rd_ptr_d];
    data_d   = (level_d != '0) ? head_d : data_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      data_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      data_q   <= data_d;
      valid_q  <= (level_d != '0);
      full_q   <= (level_d == LVL_W'(DEPTH));
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign level_o = level_q;
  assign full_o  = full_q;

endmodule : capture_fifo

// File: rtl/capture_timer_ctrl.sv
// Timestamp counter under an IDLE/RUN/HOLD FSM; capture edges push the count into a FIFO.
module capture_timer_ctrl
  import capture_pkg::*;
#(
  parameter  int unsigned CNT_W = CNT_W_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_an_i,
  input  logic             start_rise_i,
  input  logic             capture_rise_i,
  input  logic             rst_capture_rise_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             running_o,
  output logic [LVL_W-1:0] level_o,
  output logic             overflow_o,
  output logic             wrap_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             running_q, overflow_q, overflow_d, wrap_q, wrap_d;
  logic             push_c, pop_c, flush_c;
  logic             fifo_full;

  // Next-state logic; rst_capture overrides everything else in its cycle.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wrap_d     = wrap_q;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    flush_c    = 1'b0;
    if (rst_capture_rise_i) begin
      state_d    = ST_IDLE;
      count_d    = '0;
      overflow_d = 1'b0;
      wrap_d     = 1'b0;
      flush_c    = 1'b1;
    end else begin
      pop_c = rd_ready_i & rd_valid_o;
      unique case (state_q)
        ST_IDLE: begin
          if (start_rise_i) begin
            state_d = ST_RUN;
            count_d = '0;
          end
        end
        ST_RUN: begin
          push_c = capture_rise_i;
          if (start_rise_i) begin
            state_d = ST_HOLD;
          end else begin
            count_d = count_q + CNT_W'(1);
            if (&count_q) wrap_d = 1'b1;
          end
        end
        ST_HOLD: begin
          push_c = capture_rise_i;
          if (start_rise_i) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
      if (push_c && fifo_full && !pop_c) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      running_q  <= (state_d == ST_RUN);
      overflow_q <= overflow_d;
      wrap_q     <= wrap_d;
    end
  end

  capture_fifo #(
    .W     (CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_an_i (rst_an_i),
    .flush_i  (flush_c),
    .push_i   (push_c),
    .data_i   (count_q),
    .pop_i    (pop_c),
    .valid_o  (rd_valid_o),
    .data_o   (rd_data_o),
    .level_o  (level_o),
    .full_o   (fifo_full)
  );

  assign count_o    = count_q;
  assign running_o  = running_q;
  assign overflow_o = overflow_q;
  assign wrap_o     = wrap_q;

endmodule : capture_timer_ctrl
